// File: rtl/rx_fifo.sv
// rx_fifo -- first-word-fall-through receive FIFO between a receive channel
// and a memory writer.
//
// Parameters
//   WIDTH : data word width in bits
//   DEPTH : storage depth in words (power of two, >= 2)
//
// Ports
//   ACLK        in   clock, rising edge
//   ARESET      in   synchronous active-high reset
//   rx_data     in   word from the receive channel
//   rx_new_data in   rx_data valid this cycle
//   rx_hold     out  back-pressure to the receive channel
//   mem_data    out  head-of-queue word
//   mem_valid   out  mem_data holds a valid word
//   mem_ready   in   memory writer takes mem_data this cycle
//   count       out  number of stored words
//   overflow    out  sticky: a word arrived that could not be stored
//
// Build option
//   RX_FIFO_EARLY_HOLD_EN : when defined, rx_hold rises at DEPTH-1 words so a
//   word already in flight from the receive channel still finds a slot.
module rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     ACLK,
    input  logic                     ARESET,
    input  logic [WIDTH-1:0]         rx_data,
    input  logic                     rx_new_data,
    output logic                     rx_hold,
    output logic [WIDTH-1:0]         mem_data,
    output logic                     mem_valid,
    input  logic                     mem_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_PARTIAL = 2'd1,
        ST_FULL    = 2'd2
    } occ_e;

    occ_e            state_q, state_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            overflow_q, overflow_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic full;
    logic push;
    logic pop;

    // State register
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q    <= ST_EMPTY;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is not reset; a push coinciding with reset is discarded.
    always_ff @(posedge ACLK) begin
        if (push && !ARESET) begin
            mem_q[wr_ptr_q] <= rx_data;
        end
    end

    // FSM outputs: validity and fullness come from the occupancy state
    always_comb begin
        mem_valid = (state_q != ST_EMPTY);
        full      = (state_q == ST_FULL);
    end

    // A pop frees the slot in the same cycle, so a full FIFO can still accept
    // a word when the writer drains one simultaneously.
    assign pop  = mem_valid && mem_ready;
    assign push = rx_new_data && (!full || pop);

    // Next occupancy state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_EMPTY: begin
                if (push) state_d = ST_PARTIAL;
            end
            ST_PARTIAL: begin
                if (push && !pop && count_q == CW'(DEPTH - 1))
                    state_d = ST_FULL;
                else if (pop && !push && count_q == CW'(1))
                    state_d = ST_EMPTY;
            end
            ST_FULL: begin
                if (pop && !push) state_d = ST_PARTIAL;
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    // Pointers, occupancy count and sticky overflow
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        if (rx_new_data && !push) overflow_d = 1'b1;
    end

    assign mem_data = mem_q[rd_ptr_q];
    assign count    = count_q;
    assign overflow = overflow_q;

`ifdef RX_FIFO_EARLY_HOLD_EN
    assign rx_hold = (count_q >= CW'(DEPTH - 1));
`else
    assign rx_hold = (count_q == CW'(DEPTH));
`endif

endmodule

// File: tb/tb_rx_fifo.sv
// Testbench for rx_fifo (WIDTH=8, DEPTH=4): table-driven vectors with
// explicit expected outputs, a queue-based scoreboard checked every cycle,
// and hand-written sequences for full/overflow/wrap/reset corner cases.
module tb_rx_fifo;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

`ifdef RX_FIFO_EARLY_HOLD_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic             ACLK = 1'b0;
    logic             ARESET;
    logic [WIDTH-1:0] rx_data;
    logic             rx_new_data;
    logic             rx_hold;
    logic [WIDTH-1:0] mem_data;
    logic             mem_valid;
    logic             mem_ready;
    logic [CW-1:0]    count;
    logic             overflow;

    rx_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .ACLK        (ACLK),
        .ARESET      (ARESET),
        .rx_data     (rx_data),
        .rx_new_data (rx_new_data),
        .rx_hold     (rx_hold),
        .mem_data    (mem_data),
        .mem_valid   (mem_valid),
        .mem_ready   (mem_ready),
        .count       (count),
        .overflow    (overflow)
    );

    always #5 ACLK = ~ACLK;

    int n_vec = 0;
    int n_err = 0;

    // Scoreboard and reference state
    logic [WIDTH-1:0] sb[$];
    logic [WIDTH-1:0] out_log[$];
    int               m_count = 0;
    bit               m_ovf   = 1'b0;

    typedef struct {
        bit               rst;
        bit               nd;
        logic [WIDTH-1:0] d;
        bit               rdy;
        int               e_cnt;
        bit               e_vld;
        logic [WIDTH-1:0] e_data;
        bit               e_hold_std;
        bit               e_hold_early;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit rst, bit nd, logic [WIDTH-1:0] d, bit rdy,
                                int e_cnt, bit e_vld, logic [WIDTH-1:0] e_data,
                                bit e_hold_std, bit e_hold_early);
        vec_t v;
        v.rst = rst; v.nd = nd; v.d = d; v.rdy = rdy;
        v.e_cnt = e_cnt; v.e_vld = e_vld; v.e_data = e_data;
        v.e_hold_std = e_hold_std; v.e_hold_early = e_hold_early;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit model_hold(int c);
        if (EARLY) return (c >= DEPTH - 1);
        return (c == DEPTH);
    endfunction

    // One clock cycle: drive inputs, check the popped word before the edge,
    // advance the model at the edge, then compare all outputs.
    task automatic apply(input bit rst, input bit nd, input logic [WIDTH-1:0] d, input bit rdy);
        bit m_pop;
        bit m_push;
        ARESET      = rst;
        rx_new_data = nd;
        rx_data     = d;
        mem_ready   = rdy;
        #1;
        m_pop  = (m_count != 0) && rdy;
        m_push = nd && ((m_count < DEPTH) || m_pop);
        if (m_pop) begin
            check("sb_pop_data", mem_data, sb[0]);
            if (!rst) out_log.push_back(mem_data);
        end
        @(posedge ACLK);
        #1;
        if (rst) begin
            sb.delete();
            m_ovf = 1'b0;
        end else begin
            if (m_pop) void'(sb.pop_front());
            if (m_push) sb.push_back(d);
            if (nd && !m_push) m_ovf = 1'b1;
        end
        m_count = sb.size();
        check("count", count, m_count);
        check("mem_valid", mem_valid, (m_count != 0));
        check("rx_hold", rx_hold, model_hold(m_count));
        check("overflow", overflow, m_ovf);
        if (m_count != 0) check("mem_data", mem_data, sb[0]);
    endtask

    function automatic bit logged(logic [WIDTH-1:0] w);
        foreach (out_log[i]) if (out_log[i] == w) return 1'b1;
        return 1'b0;
    endfunction

    initial begin
        ARESET = 1'b1; rx_new_data = 1'b0; rx_data = '0; mem_ready = 1'b0;

        // Reset, single word hold, fill to full, drain in order
        tbl.push_back(mk(1, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0));
        tbl.push_back(mk(0, 1, 8'hA5, 0, 1, 1, 8'hA5, 0, 0));
        for (int i = 0; i < 5; i++) tbl.push_back(mk(0, 0, 8'h00, 0, 1, 1, 8'hA5, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 1, 0, 0, 8'h00, 0, 0));
        tbl.push_back(mk(0, 1, 8'h01, 0, 1, 1, 8'h01, 0, 0));
        tbl.push_back(mk(0, 1, 8'h02, 0, 2, 1, 8'h01, 0, 0));
        tbl.push_back(mk(0, 1, 8'h03, 0, 3, 1, 8'h01, 0, 1));
        tbl.push_back(mk(0, 1, 8'h04, 0, 4, 1, 8'h01, 1, 1));
        tbl.push_back(mk(0, 0, 8'h00, 1, 3, 1, 8'h02, 0, 1));
        tbl.push_back(mk(0, 0, 8'h00, 1, 2, 1, 8'h03, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 1, 1, 1, 8'h04, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 1, 0, 0, 8'h00, 0, 0));

        foreach (tbl[i]) begin
            apply(tbl[i].rst, tbl[i].nd, tbl[i].d, tbl[i].rdy);
            check($sformatf("tbl%0d_count", i), count, tbl[i].e_cnt);
            check($sformatf("tbl%0d_valid", i), mem_valid, tbl[i].e_vld);
            if (tbl[i].e_vld) check($sformatf("tbl%0d_data", i), mem_data, tbl[i].e_data);
            check($sformatf("tbl%0d_hold", i), rx_hold,
                  EARLY ? tbl[i].e_hold_early : tbl[i].e_hold_std);
        end
        out_log.delete();

        // Full with simultaneous push and pop
        for (int i = 0; i < 4; i++) apply(0, 1, 8'h10 + 8'(i), 0);
        check("full_count", count, 4);
        apply(0, 1, 8'h20, 1);
        check("pp_count", count, 4);
        check("pp_overflow", overflow, 0);
        check("pp_popped", out_log[out_log.size()-1], 8'h10);
        for (int i = 0; i < 4; i++) apply(0, 0, 8'h00, 1);
        check("pp_order0", out_log[1], 8'h11);
        check("pp_order1", out_log[2], 8'h12);
        check("pp_order2", out_log[3], 8'h13);
        check("pp_order3", out_log[4], 8'h20);
        out_log.delete();

        // Overflow drop, sticky across idle cycles
        for (int i = 0; i < 4; i++) apply(0, 1, 8'h30 + 8'(i), 0);
        apply(0, 1, 8'h55, 0);
        check("ovf_set", overflow, 1);
        check("ovf_count", count, 4);
        for (int i = 0; i < 20; i++) apply(0, 0, 8'h00, 0);
        check("ovf_sticky", overflow, 1);
        for (int i = 0; i < 4; i++) apply(0, 0, 8'h00, 1);
        check("ovf_dropped", logged(8'h55), 0);
        check("ovf_last", out_log[3], 8'h33);
        out_log.delete();

        // Reset mid-operation with same-cycle push and pop
        for (int i = 0; i < 3; i++) apply(0, 1, 8'h40 + 8'(i), 0);
        apply(1, 1, 8'h77, 1);
        check("rst_count", count, 0);
        check("rst_valid", mem_valid, 0);
        check("rst_overflow", overflow, 0);
        check("rst_hold", rx_hold, 0);
        for (int i = 0; i < 3; i++) apply(0, 0, 8'h00, 1);
        check("rst_no77", logged(8'h77), 0);
        check("rst_empty", mem_valid, 0);
        out_log.delete();

        // Streaming push/pop across pointer wraps; ready ignored while empty
        for (int i = 0; i < 16; i++) begin
            apply(0, 1, 8'(i), 1);
            check($sformatf("stream%0d_count_le1", i), (count <= 1), 1);
        end
        apply(0, 0, 8'h00, 1);
        check("stream_len", out_log.size(), 16);
        for (int i = 0; i < 16; i++) begin
            if (i < out_log.size()) check($sformatf("stream_word%0d", i), out_log[i], 8'(i));
        end
        check("stream_empty", mem_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
